// File: rtl/raster_attr_interp.sv
// Three-stage barycentric attribute interpolator with valid/ready flow control.
// Optional build macro ATTR_ROUND_EN selects round-half-up instead of truncation.
module raster_attr_interp #(
  parameter int NUM_CH = 3,
  parameter int CH_W   = 8,
  parameter int FRAC_W = 16,
  parameter int SIDE_W = 192
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [15:0]              i_x_pos,
  input  logic [15:0]              i_y_pos,
  input  logic [31:0]              i_w1,
  input  logic [31:0]              i_w2,
  input  logic [31:0]              i_w3,
  input  logic [NUM_CH*CH_W-1:0]   i_v1_attr,
  input  logic [NUM_CH*CH_W-1:0]   i_v2_attr,
  input  logic [NUM_CH*CH_W-1:0]   i_v3_attr,
  input  logic [SIDE_W-1:0]        i_side,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [15:0]              o_x,
  output logic [15:0]              o_y,
  output logic [NUM_CH*CH_W-1:0]   o_attr,
  output logic [SIDE_W-1:0]        o_side,
  output logic [31:0]              o_pix_count,
  output logic                     o_busy
);

  localparam int PROD_W = CH_W + 33;
  localparam int SUM_W  = CH_W + 35;

  logic              advance;
  logic              s1_valid_reg, s2_valid_reg, s3_valid_reg;
  logic [15:0]       s1_x_reg, s2_x_reg, s3_x_reg;
  logic [15:0]       s1_y_reg, s2_y_reg, s3_y_reg;
  logic [SIDE_W-1:0] s1_side_reg, s2_side_reg, s3_side_reg;
  logic [31:0]       pix_count_reg;

  // One global enable: the whole pipe moves or the whole pipe holds.
  assign advance     = !s3_valid_reg | i_ready;
  assign o_ready     = advance;
  assign o_valid     = s3_valid_reg;
  assign o_busy      = s1_valid_reg | s2_valid_reg | s3_valid_reg;
  assign o_x         = s3_x_reg;
  assign o_y         = s3_y_reg;
  assign o_side      = s3_side_reg;
  assign o_pix_count = pix_count_reg;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      s1_valid_reg  <= 1'b0;
      s2_valid_reg  <= 1'b0;
      s3_valid_reg  <= 1'b0;
      s3_x_reg      <= '0;
      s3_y_reg      <= '0;
      s3_side_reg   <= '0;
      pix_count_reg <= '0;
    end else begin
      if (s3_valid_reg && i_ready)
        pix_count_reg <= pix_count_reg + 32'd1;
      if (advance) begin
        s1_valid_reg <= i_valid;
        s2_valid_reg <= s1_valid_reg;
        s3_valid_reg <= s2_valid_reg;
        s1_x_reg     <= i_x_pos;
        s1_y_reg     <= i_y_pos;
        s1_side_reg  <= i_side;
        s2_x_reg     <= s1_x_reg;
        s2_y_reg     <= s1_y_reg;
        s2_side_reg  <= s1_side_reg;
        // Output registers only load real pixels so they hold while idle.
        if (s2_valid_reg) begin
          s3_x_reg    <= s2_x_reg;
          s3_y_reg    <= s2_y_reg;
          s3_side_reg <= s2_side_reg;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic signed [PROD_W-1:0] p1_next, p2_next, p3_next;
      logic signed [PROD_W-1:0] p1_reg, p2_reg, p3_reg;
      logic signed [SUM_W-1:0]  sum_next, sum_reg, q;
      logic [CH_W-1:0]          sat;
      logic [CH_W-1:0]          attr_reg;

      assign p1_next = PROD_W'($signed({1'b0, i_v1_attr[gi*CH_W +: CH_W]})) * PROD_W'($signed(i_w1));
      assign p2_next = PROD_W'($signed({1'b0, i_v2_attr[gi*CH_W +: CH_W]})) * PROD_W'($signed(i_w2));
      assign p3_next = PROD_W'($signed({1'b0, i_v3_attr[gi*CH_W +: CH_W]})) * PROD_W'($signed(i_w3));

`ifdef ATTR_ROUND_EN
      localparam logic signed [SUM_W-1:0] ROUND_HALF = {{(SUM_W-1){1'b0}}, 1'b1} << (FRAC_W - 1);
      assign sum_next = SUM_W'(p1_reg) + SUM_W'(p2_reg) + SUM_W'(p3_reg) + ROUND_HALF;
`else
      assign sum_next = SUM_W'(p1_reg) + SUM_W'(p2_reg) + SUM_W'(p3_reg);
`endif

      assign q = sum_reg >>> FRAC_W;

      // Clamp to the unsigned channel range: negative -> 0, too large -> all ones.
      always_comb begin
        sat = q[CH_W-1:0];
        if (q[SUM_W-1])
          sat = '0;
        else if (|q[SUM_W-2:CH_W])
          sat = '1;
      end

      always_ff @(posedge i_clk) begin
        if (i_reset) begin
          attr_reg <= '0;
        end else if (advance) begin
          p1_reg  <= p1_next;
          p2_reg  <= p2_next;
          p3_reg  <= p3_next;
          sum_reg <= sum_next;
          if (s2_valid_reg)
            attr_reg <= sat;
        end
      end

      assign o_attr[gi*CH_W +: CH_W] = attr_reg;
    end
  endgenerate

endmodule

// File: tb/tb_raster_attr_interp.sv
// Directed and random checks of raster_attr_interp against an arithmetic scoreboard model.
module tb_raster_attr_interp;

  localparam int NUM_CH = 3;
  localparam int CH_W   = 8;
  localparam int FRAC_W = 16;
  localparam int SIDE_W = 192;
  localparam int AW     = NUM_CH * CH_W;
`ifdef ATTR_ROUND_EN
  localparam logic [7:0] BLEND = 8'd113;
`else
  localparam logic [7:0] BLEND = 8'd112;
`endif

  typedef struct {
    logic [15:0]       x;
    logic [15:0]       y;
    logic [AW-1:0]     attr;
    logic [SIDE_W-1:0] side;
  } pix_t;

  logic              i_clk = 1'b0;
  logic              rst, in_valid, out_ready;
  logic              o_ready, o_valid, o_busy;
  logic [15:0]       x_pos, y_pos, o_x, o_y;
  logic [31:0]       w1, w2, w3, o_pix_count;
  logic [AW-1:0]     a1, a2, a3, o_attr;
  logic [SIDE_W-1:0] side, o_side;

  int          checks = 0;
  int          errors = 0;
  pix_t        exp_q[$];
  logic [31:0] exp_count;
  bit          last_acc;

  always #5 i_clk = ~i_clk;

  raster_attr_interp #(.NUM_CH(NUM_CH), .CH_W(CH_W), .FRAC_W(FRAC_W), .SIDE_W(SIDE_W)) dut (
    .i_clk(i_clk), .i_reset(rst), .i_valid(in_valid), .o_ready(o_ready),
    .i_x_pos(x_pos), .i_y_pos(y_pos), .i_w1(w1), .i_w2(w2), .i_w3(w3),
    .i_v1_attr(a1), .i_v2_attr(a2), .i_v3_attr(a3), .i_side(side),
    .o_valid(o_valid), .i_ready(out_ready), .o_x(o_x), .o_y(o_y),
    .o_attr(o_attr), .o_side(o_side), .o_pix_count(o_pix_count), .o_busy(o_busy)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Weighted sum in plain 64-bit arithmetic, then shift and clamp.
  function automatic logic [AW-1:0] model_attr(input logic [AW-1:0] va, vb, vc,
                                               input logic [31:0] wa, wb, wc);
    logic [AW-1:0] r;
    for (int k = 0; k < NUM_CH; k++) begin
      longint s, q;
      longint ea = va[k*CH_W +: CH_W];
      longint eb = vb[k*CH_W +: CH_W];
      longint ec = vc[k*CH_W +: CH_W];
      longint fa = $signed(wa);
      longint fb = $signed(wb);
      longint fc = $signed(wc);
      s = ea * fa + eb * fb + ec * fc;
`ifdef ATTR_ROUND_EN
      s = s + (64'sd1 <<< (FRAC_W - 1));
`endif
      q = s >>> FRAC_W;
      if (q < 0) q = 0;
      if (q > 255) q = 255;
      r[k*CH_W +: CH_W] = q[7:0];
    end
    return r;
  endfunction

  // One clock: settle, check, score transfers, then step to the next falling edge.
  task automatic tick();
    pix_t p;
    #1;
    check("ready_rule", o_ready, !o_valid | out_ready);
    check("pix_count", o_pix_count, exp_count);
    last_acc = 1'b0;
    if (!rst) begin
      if (o_valid && out_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL spurious_out observed=valid expected=no_pixel");
        end
        if (exp_q.size() != 0) begin
          p = exp_q.pop_front();
          check("out_x", o_x, p.x);
          check("out_y", o_y, p.y);
          check("out_attr", o_attr, p.attr);
          check("out_side", o_side, p.side);
          exp_count = exp_count + 32'd1;
        end
      end
      if (in_valid && o_ready) begin
        p.x = x_pos; p.y = y_pos; p.side = side;
        p.attr = model_attr(a1, a2, a3, w1, w2, w3);
        exp_q.push_back(p);
        last_acc = 1'b1;
      end
    end
    @(posedge i_clk);
    if (rst) begin
      exp_q.delete();
      exp_count = '0;
    end
    @(negedge i_clk);
  endtask

  task automatic rand_pix();
    x_pos = 16'($urandom);
    y_pos = 16'($urandom);
    side  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    a1 = 24'($urandom); a2 = 24'($urandom); a3 = 24'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      w1 = $urandom; w2 = $urandom; w3 = $urandom;
    end else begin
      w1 = 32'($urandom_range(0, 32'h20000)) - 32'h8000;
      w2 = 32'($urandom_range(0, 32'h20000)) - 32'h8000;
      w3 = 32'($urandom_range(0, 32'h20000)) - 32'h8000;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; exp_count = '0;
    rand_pix();
    @(negedge i_clk);
    do_reset();
    check("rst_valid", o_valid, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    check("rst_ready", o_ready, 1'b1);
    check("rst_attr", o_attr, '0);
    check("rst_xy", {o_x, o_y}, '0);
    check("rst_side", o_side, '0);

    // Identity pixel and latency.
    rand_pix();
    a1 = {8'd0, 8'd0, 8'd255}; a2 = '0; a3 = '0;
    w1 = 32'h0001_0000; w2 = '0; w3 = '0;
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    check("id_busy", o_busy, 1'b1);
    tick();
    check("id_lat_early", o_valid, 1'b0);
    tick();
    check("id_lat_valid", o_valid, 1'b1);
    check("id_attr", o_attr, 24'h0000FF);
    tick();

    // Blend: 100/2 + 200/4 + 50/4 = 112.5.
    a1 = {3{8'd100}}; a2 = {3{8'd200}}; a3 = {3{8'd50}};
    w1 = 32'h8000; w2 = 32'h4000; w3 = 32'h4000;
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    tick(); tick();
    check("blend_valid", o_valid, 1'b1);
    check("blend_attr", o_attr, {3{BLEND}});

    // Saturation high then low, back to back.
    a1 = {3{8'd255}}; a2 = '0; a3 = '0; w1 = 32'h18000; w2 = '0; w3 = '0;
    in_valid = 1'b1; tick();
    a1 = {3{8'd10}}; w1 = 32'hFFFF_0000;
    tick(); in_valid = 1'b0;
    tick();
    check("sat_hi", o_attr, 24'hFFFFFF);
    tick();
    check("sat_lo", o_attr, 24'h000000);
    drain();
    check("idle_busy", o_busy, 1'b0);

    // Backpressure: 8 pixels with a 5-cycle i_ready drop mid-stream.
    do_reset();
    begin
      int sent = 0;
      rand_pix();
      for (int cyc = 0; cyc < 40; cyc++) begin
        in_valid  = (sent < 8);
        out_ready = !(cyc >= 5 && cyc < 10);
        tick();
        if (last_acc) begin sent++; rand_pix(); end
      end
      check("bp_sent", sent, 8);
    end
    drain();
    check("bp_count", o_pix_count, 32'd8);

    // Random traffic with random backpressure.
    rand_pix();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      if (last_acc) rand_pix();
    end
    drain();

    // Reset with three pixels in flight.
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin rand_pix(); tick(); end
    in_valid = 1'b0;
    check("mid_busy", o_busy, 1'b1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mid_valid", o_valid, 1'b0);
    check("mid_busy0", o_busy, 1'b0);
    check("mid_count", o_pix_count, 32'd0);
    check("mid_ready", o_ready, 1'b1);
    check("mid_attr", o_attr, '0);
    tick(); tick(); tick();
    check("mid_no_ghost", o_valid, 1'b0);

    // Counter wrap from 0xFFFFFFFE.
    force dut.pix_count_reg = 32'hFFFF_FFFE;
    #1;
    release dut.pix_count_reg;
    exp_count = 32'hFFFF_FFFE;
    in_valid = 1'b1;
    rand_pix(); tick();
    rand_pix(); tick();
    drain();
    check("wrap_count", o_pix_count, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
